// File: rtl/cook_pkg.sv
// cook_pkg: shared state encoding and timing defaults for the egg-timer controller.
package cook_pkg;
  typedef enum logic [2:0] {OFF, IDLE, PROG, RUN, PAUSE, ALARM} state_e;
  localparam int REPEAT_DELAY_DEF = 3;
  localparam int ALARM_SECONDS_DEF = 10;
endpackage

// File: rtl/repeat_gen.sv
// repeat_gen: held-button auto-repeat, one strobe on press then one per tick after a hold delay.
module repeat_gen
  import cook_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic level,
  input  logic tick,
  output logic strobe
);
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] LAST = CW'(REPEAT_DELAY - 1);
  logic held_q, active, rpt, strobe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Gating by enable clears held_q, so a button held on entry counts as a fresh press.
  always_comb begin
    active = enable & level;
    rpt = active & held_q & tick & (cnt_q == LAST);
    cnt_d = !(active && held_q) ? '0 : (tick && cnt_q != LAST) ? cnt_q + CW'(1) : cnt_q;
    strobe_d = active & (~held_q | rpt);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      held_q <= 1'b0;
      cnt_q <= '0;
      strobe <= 1'b0;
    end else begin
      held_q <= active;
      cnt_q <= cnt_d;
      strobe <= strobe_d;
    end
endmodule

// File: rtl/cook_controller.sv
// cook_controller: egg-timer sequencing FSM driving counter load/enable, set-button repeat, display select and LEDs.
module cook_controller
  import cook_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int ALARM_SECONDS = ALARM_SECONDS_DEF,
  parameter int ALARM_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_1s,
  input  logic pulse_300ms,
  input  logic timer_en,
  input  logic cooktime_req,
  input  logic start_btn,
  input  logic seconds_req,
  input  logic minutes_req,
  input  logic prog_zero,
  input  logic timer_zero,
  output logic increment_seconds,
  output logic increment_minutes,
  output logic prog_mode,
  output logic load_timer,
  output logic main_timer_enable,
  output logic display_prog,
  output logic timer_enabled_led,
  output logic timer_on_led,
  output logic alarm_led
);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_SECONDS - 1);
  state_e state_q, state_d;
  logic start_q, cook_q, start_rise, cook_rise, zero_seen, alarm_done, stay_alarm;
  logic load_d, en_d, prog_d, disp_d, led_en_d, led_on_d, alarm_d;
  logic [ALARM_W-1:0] cnt_q, cnt_d;
  assign start_rise = start_btn & ~start_q;
  assign cook_rise = cooktime_req & ~cook_q;
  // The counter still shows its old value during the load cycle, so ignore zero then.
  assign zero_seen = timer_zero & ~load_timer;
  assign alarm_done = pulse_1s & (cnt_q == ALARM_LAST);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= OFF;
      start_q <= 1'b0;
      cook_q <= 1'b0;
      cnt_q <= '0;
      prog_mode <= 1'b0;
      load_timer <= 1'b0;
      main_timer_enable <= 1'b0;
      display_prog <= 1'b0;
      timer_enabled_led <= 1'b0;
      timer_on_led <= 1'b0;
      alarm_led <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_btn;
      cook_q <= cooktime_req;
      cnt_q <= cnt_d;
      prog_mode <= prog_d;
      load_timer <= load_d;
      main_timer_enable <= en_d;
      display_prog <= disp_d;
      timer_enabled_led <= led_en_d;
      timer_on_led <= led_on_d;
      alarm_led <= alarm_d;
    end
  always_comb begin
    state_d = state_q;
    if (!timer_en) state_d = OFF;
    else
      case (state_q)
        OFF:     state_d = IDLE;
        IDLE:    state_d = cook_rise ? PROG : (start_rise && !prog_zero) ? RUN : IDLE;
        PROG:    state_d = cook_rise ? IDLE : (start_rise && !prog_zero) ? RUN : PROG;
        RUN:     state_d = zero_seen ? ALARM : start_rise ? PAUSE : RUN;
        PAUSE:   state_d = start_rise ? RUN : cook_rise ? PROG : PAUSE;
        ALARM:   state_d = (alarm_done | start_rise | cook_rise | seconds_req | minutes_req) ? IDLE : ALARM;
        default: state_d = OFF;
      endcase
  end
  always_comb begin
    load_d = (state_d == RUN) && (state_q == IDLE || state_q == PROG);
    en_d = (state_d == RUN) && !load_d;
    prog_d = state_d == PROG;
    disp_d = state_d == IDLE || state_d == PROG;
    led_en_d = state_d != OFF;
    led_on_d = state_d == RUN;
    stay_alarm = state_q == ALARM && state_d == ALARM;
    alarm_d = state_d != ALARM ? 1'b0 : !stay_alarm ? 1'b1 : alarm_led ^ pulse_1s;
    cnt_d = stay_alarm ? cnt_q + ALARM_W'(pulse_1s) : '0;
  end
  repeat_gen #(.REPEAT_DELAY(REPEAT_DELAY)) u_rep_sec (
    .clk(clk), .reset(reset), .enable(state_d == PROG), .level(seconds_req),
    .tick(pulse_300ms), .strobe(increment_seconds)
  );
  repeat_gen #(.REPEAT_DELAY(REPEAT_DELAY)) u_rep_min (
    .clk(clk), .reset(reset), .enable(state_d == PROG), .level(minutes_req),
    .tick(pulse_300ms), .strobe(increment_minutes)
  );
endmodule

// File: tb/tb_cook_controller.sv
// tb_cook_controller: directed self-checking bench for the egg-timer controller.
module tb_cook_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic pulse_1s = 0, pulse_300ms = 0, timer_en = 0, cooktime_req = 0, start_btn = 0;
  logic seconds_req = 0, minutes_req = 0, prog_zero = 0, timer_zero = 0;
  logic increment_seconds, increment_minutes, prog_mode, load_timer, main_timer_enable;
  logic display_prog, timer_enabled_led, timer_on_led, alarm_led;
  logic [8:0] o;
  int tests = 0, fails = 0;
  // {inc_s, inc_m, prog, load, en, disp, en_led, on_led, alarm}
  localparam logic [8:0] O_OFF = 9'b000000000, O_IDLE = 9'b000001100, O_PROG = 9'b001001100;
  localparam logic [8:0] O_RUNL = 9'b000100110, O_RUN = 9'b000010110, O_PAUSE = 9'b000000100;
  localparam logic [8:0] O_AL1 = 9'b000000101, O_AL0 = 9'b000000100;
  localparam logic [8:0] O_PROG_S = 9'b101001100, O_PROG_M = 9'b011001100, O_PROG_SM = 9'b111001100;

  cook_controller dut (
    .clk(clk), .reset(reset), .pulse_1s(pulse_1s), .pulse_300ms(pulse_300ms),
    .timer_en(timer_en), .cooktime_req(cooktime_req), .start_btn(start_btn),
    .seconds_req(seconds_req), .minutes_req(minutes_req), .prog_zero(prog_zero),
    .timer_zero(timer_zero), .increment_seconds(increment_seconds),
    .increment_minutes(increment_minutes), .prog_mode(prog_mode), .load_timer(load_timer),
    .main_timer_enable(main_timer_enable), .display_prog(display_prog),
    .timer_enabled_led(timer_enabled_led), .timer_on_led(timer_on_led), .alarm_led(alarm_led)
  );
  assign o = {increment_seconds, increment_minutes, prog_mode, load_timer, main_timer_enable,
              display_prog, timer_enabled_led, timer_on_led, alarm_led};
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_s, n_m, prev, wide;
    step(); step();
    check("reset_outs", int'(o), int'(O_OFF));
    reset = 0;
    step();
    check("off_hold", int'(o), int'(O_OFF));
    timer_en = 1;
    step();
    check("enable_idle", int'(o), int'(O_IDLE));
    // zero program: start edge must not load or leave IDLE
    prog_zero = 1; start_btn = 1;
    step();
    check("zero_start_idle", int'(o), int'(O_IDLE));
    start_btn = 0;
    step();
    cooktime_req = 1;
    step();
    check("enter_prog", int'(o), int'(O_PROG));
    cooktime_req = 0;
    step();
    // seconds held for 10 repeat ticks
    seconds_req = 1;
    step();
    check("sec_press_strobe", int'(o), int'(O_PROG_S));
    step();
    check("sec_press_width", int'(o), int'(O_PROG));
    n_s = 0; n_m = 0; prev = 0; wide = 0;
    for (int i = 0; i < 10; i++) begin
      pulse_300ms = 1;
      for (int c = 0; c < 3; c++) begin
        step();
        pulse_300ms = 0;
        n_s += int'(increment_seconds);
        n_m += int'(increment_minutes);
        if (prev == 1 && increment_seconds) wide++;
        prev = int'(increment_seconds);
      end
    end
    check("sec_repeat_count", n_s, 8);
    check("sec_strobe_width", wide, 0);
    check("min_quiet", n_m, 0);
    seconds_req = 0;
    step();
    pulse_300ms = 1;
    step();
    pulse_300ms = 0;
    check("sec_release_quiet", int'(o), int'(O_PROG));
    minutes_req = 1;
    step();
    check("min_press_strobe", int'(o), int'(O_PROG_M));
    minutes_req = 0;
    step();
    start_btn = 1;
    step();
    check("zero_start_prog", int'(o), int'(O_PROG));
    start_btn = 0;
    step();
    // start / pause / resume
    prog_zero = 0; start_btn = 1;
    step();
    check("run_load", int'(o), int'(O_RUNL));
    step();
    check("run_enable", int'(o), int'(O_RUN));
    start_btn = 0;
    step();
    check("run_steady", int'(o), int'(O_RUN));
    start_btn = 1;
    step();
    check("pause", int'(o), int'(O_PAUSE));
    start_btn = 0;
    step();
    start_btn = 1;
    step();
    check("resume_no_load", int'(o), int'(O_RUN));
    start_btn = 0;
    step();
    // timer_zero beats a same-cycle start edge
    timer_zero = 1; start_btn = 1;
    step();
    check("alarm_entry", int'(o), int'(O_AL1));
    timer_zero = 0; start_btn = 0;
    step();
    check("alarm_hold", int'(o), int'(O_AL1));
    for (int i = 1; i <= 10; i++) begin
      pulse_1s = 1;
      step();
      pulse_1s = 0;
      check($sformatf("alarm_pulse%0d", i), int'(o),
            int'(i == 10 ? O_IDLE : (i % 2 == 1) ? O_AL0 : O_AL1));
      step();
    end
    // second alarm cut short by a seconds press at pulse 4
    start_btn = 1;
    step();
    check("run_load2", int'(o), int'(O_RUNL));
    start_btn = 0;
    step();
    timer_zero = 1;
    step();
    check("alarm2_entry", int'(o), int'(O_AL1));
    timer_zero = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_1s = 1;
      step();
      pulse_1s = 0;
      step();
    end
    check("alarm2_pulse3", int'(o), int'(O_AL0));
    pulse_1s = 1; seconds_req = 1;
    step();
    pulse_1s = 0;
    check("alarm2_abort", int'(o), int'(O_IDLE));
    seconds_req = 0;
    step();
    // drop timer_en mid-run
    start_btn = 1;
    step();
    start_btn = 0;
    step();
    check("run_again", int'(o), int'(O_RUN));
    timer_en = 0;
    step();
    check("en_drop_off", int'(o), int'(O_OFF));
    timer_en = 1;
    step();
    check("reenable_idle", int'(o), int'(O_IDLE));
    // async reset in PROG with both buttons held
    cooktime_req = 1;
    step();
    cooktime_req = 0;
    seconds_req = 1; minutes_req = 1;
    step();
    check("both_strobe", int'(o), int'(O_PROG_SM));
    step();
    #2 reset = 1;
    #1 check("async_reset", int'(o), int'(O_OFF));
    step();
    seconds_req = 0; minutes_req = 0;
    step();
    reset = 0;
    step();
    check("post_reset_idle", int'(o), int'(O_IDLE));
    pulse_300ms = 1;
    step();
    pulse_300ms = 0;
    check("post_reset_quiet", int'(o), int'(O_IDLE));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
